// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, frame FSM with parity/stop checking,
// and a first-word-fall-through receive FIFO with parity/framing/overrun pulses.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 651,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_RX_Serial,
    input  logic                                 i_RX_Read,
    output logic                                 o_RX_DV,
    output logic [DATA_BITS-1:0]                 o_RX_Byte,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_RX_Count,
    output logic                                 o_RX_Busy,
    output logic                                 o_Parity_Err,
    output logic                                 o_Frame_Err,
    output logic                                 o_Overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] MID      = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic [CW-1:0]    FULL     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, frm_bad, commit, last_stop;
    logic                 bit_tick, par_exp;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, do_wr, do_rd;

    assign bit_tick = (cnt == LAST);
    assign par_exp  = (^shreg) ^ (PARITY_MODE == 2);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        last_stop = 1'b0;
        unique case (state)
            IDLE:   if (!rx_s) state_n = START;
            START:  if (cnt == MID) state_n = rx_s ? IDLE : DATA;
            DATA:   if (bit_tick && bit_idx == BIT_LAST)
                        state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY: if (bit_tick) state_n = STOP;
            STOP:   if (bit_tick && stop_idx == STOP_LAST) begin
                        state_n   = IDLE;
                        last_stop = 1'b1;
                    end
            default: state_n = IDLE;
        endcase
    end

    // Counter restarts on every state change so each phase measures from its own entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bad  <= 1'b0;
            frm_bad  <= 1'b0;
            commit   <= 1'b0;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
            cnt     <= (state_n != state || bit_tick || state == IDLE) ? '0 : cnt + 1'b1;
            commit  <= last_stop;
            if (state == START && state_n == DATA) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                par_bad  <= 1'b0;
                frm_bad  <= 1'b0;
            end
            if (state == DATA && bit_tick) bit_idx <= bit_idx + 1'b1;
            if (state == PARITY && bit_tick) par_bad <= (rx_s != par_exp);
            if (state == STOP && bit_tick) begin
                stop_idx <= 1'b1;
                if (!rx_s) frm_bad <= 1'b1;
            end
        end
    end

    // Shift register holds the frame until commit; the next frame cannot sample data before then.
    always_ff @(posedge i_clk) begin
        if (state == DATA && bit_tick) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end

    assign full  = (count == FULL);
    assign do_wr = commit && !frm_bad && !par_bad && (!full || i_RX_Read);
    assign do_rd = i_RX_Read && (count != '0 || do_wr);

    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            o_Frame_Err  <= commit && frm_bad;
            o_Parity_Err <= commit && !frm_bad && par_bad;
            o_Overrun    <= commit && !frm_bad && !par_bad && full && !i_RX_Read;
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_RX_DV    = (count != '0);
    assign o_RX_Byte  = o_RX_DV ? mem[rd_ptr] : '0;
    assign o_RX_Count = count;
    assign o_RX_Busy  = (state == DATA) || (state == PARITY) || (state == STOP);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8E1/depth 4, 7O2/depth 4, 8N1/depth 16)
// driven by a bit-level transmitter task; pulse widths are checked by counting high cycles.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] rx, rd;
    logic       dv0, dv1, dv2;
    logic [7:0] by0, by2;
    logic [6:0] by1;
    logic [2:0] cnt0, cnt1;
    logic [4:0] cnt2;
    logic [2:0] busy, pe, fe, ov;

    int checks = 0, failures = 0;
    int pe_n[3], fe_n[3], ov_n[3], busy_n[3];
    int base;

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e81 (
        .i_clk(clk), .i_rst(rst), .i_RX_Serial(rx[0]), .i_RX_Read(rd[0]),
        .o_RX_DV(dv0), .o_RX_Byte(by0), .o_RX_Count(cnt0), .o_RX_Busy(busy[0]),
        .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Overrun(ov[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_o72 (
        .i_clk(clk), .i_rst(rst), .i_RX_Serial(rx[1]), .i_RX_Read(rd[1]),
        .o_RX_DV(dv1), .o_RX_Byte(by1), .o_RX_Count(cnt1), .o_RX_Busy(busy[1]),
        .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Overrun(ov[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_n81 (
        .i_clk(clk), .i_rst(rst), .i_RX_Serial(rx[2]), .i_RX_Read(rd[2]),
        .o_RX_DV(dv2), .o_RX_Byte(by2), .o_RX_Count(cnt2), .o_RX_Busy(busy[2]),
        .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Overrun(ov[2]));

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            pe_n[i]   += int'(pe[i]);
            fe_n[i]   += int'(fe[i]);
            ov_n[i]   += int'(ov[i]);
            busy_n[i] += int'(busy[i]);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int head(input int ch);
        case (ch)
            0:       return int'(by0);
            1:       return int'(by1);
            default: return int'(by2);
        endcase
    endfunction

    function automatic int occ(input int ch);
        case (ch)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop(input int ch);
        @(negedge clk);
        rd[ch] = 1'b1;
        @(negedge clk);
        rd[ch] = 1'b0;
    endtask

    // One frame, 16 clks per bit. pbad flips the parity bit, stop_lo drives stop bits low,
    // rd_commit pulses a read in the cycle busy drops, rst_bit pulses reset mid data bit.
    task automatic send(input int ch, input int nb, input int d, input int pm, input int pbad,
                        input int ns, input int stop_lo, input int rd_commit, input int rst_bit);
        logic p;
        bit   fired;
        p = 1'b0;
        for (int i = 0; i < nb; i++) p ^= d[i];
        if (pm == 2) p = ~p;
        if (pbad != 0) p = ~p;
        @(negedge clk);
        rx[ch] = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx[ch] = d[i];
            if (i == rst_bit) begin
                repeat (8) @(negedge clk);
                chk("busy_mid_frame", int'(busy[ch]), 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                rx[ch] = 1'b1;
                return;
            end
            repeat (16) @(negedge clk);
        end
        if (pm != 0) begin
            rx[ch] = p;
            repeat (16) @(negedge clk);
        end
        fired = 1'b0;
        for (int s = 0; s < ns; s++) begin
            rx[ch] = (stop_lo != 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                if (rd[ch]) rd[ch] = 1'b0;
                else if (rd_commit != 0 && s == ns - 1 && !fired && !busy[ch]) begin
                    rd[ch] = 1'b1;
                    fired  = 1'b1;
                end
            end
        end
        rx[ch] = 1'b1;
        if (rd_commit != 0) chk("commit_read_window", int'(fired), 1);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 3'b111;
        rd  = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_dv",    int'(dv0), 0);
        chk("rst_count", occ(0), 0);
        chk("rst_byte",  head(0), 0);
        chk("rst_busy",  int'(busy[0]), 0);
        chk("rst_pulses", int'({pe[0], fe[0], ov[0]}), 0);
        rst = 1'b0;
        idle(4);

        // 8N1 basic receive and read-out
        send(2, 8, 'hF5, 0, 0, 1, 0, 0, -1);
        idle(4);
        chk("n81_dv",    int'(dv2), 1);
        chk("n81_byte",  head(2), 'hF5);
        chk("n81_count", occ(2), 1);
        pop(2);
        chk("n81_count_after_read", occ(2), 0);
        chk("n81_byte_after_read",  head(2), 0);

        // even parity: bad then good
        base = pe_n[0];
        send(0, 8, 'hAB, 1, 1, 1, 0, 0, -1);
        idle(4);
        chk("parity_err_pulses", pe_n[0] - base, 1);
        chk("parity_err_count",  occ(0), 0);
        send(0, 8, 'hAB, 1, 0, 1, 0, 0, -1);
        idle(4);
        chk("parity_good_byte", head(0), 'hAB);
        pop(0);
        chk("parity_good_drained", occ(0), 0);

        // framing error, then recovery
        base = fe_n[0];
        send(0, 8, 'h3D, 1, 0, 1, 1, 0, -1);
        idle(40);
        chk("frame_err_pulses", fe_n[0] - base, 1);
        chk("frame_err_count",  occ(0), 0);
        send(0, 8, 'hDC, 1, 0, 1, 0, 0, -1);
        idle(4);
        chk("frame_recover_byte", head(0), 'hDC);
        pop(0);

        // fill depth-4 FIFO, overrun on 5th, read-at-commit on 6th
        base = ov_n[0];
        for (int v = 1; v <= 5; v++) begin
            send(0, 8, v, 1, 0, 1, 0, 0, -1);
            idle(4);
        end
        chk("full_count",     occ(0), 4);
        chk("overrun_pulses", ov_n[0] - base, 1);
        chk("full_head",      head(0), 'h01);
        send(0, 8, 'h06, 1, 0, 1, 0, 1, -1);
        idle(4);
        chk("rw_commit_count",   occ(0), 4);
        chk("rw_commit_head",    head(0), 'h02);
        chk("rw_commit_overrun", ov_n[0] - base, 1);
        pop(0);
        chk("drain_head_03", head(0), 'h03);
        pop(0);
        chk("drain_head_04", head(0), 'h04);
        pop(0);
        chk("drain_head_06", head(0), 'h06);

        // glitch rejection, then 7O2
        @(negedge clk);
        rx[1] = 1'b0;
        idle(5);
        rx[1] = 1'b1;
        idle(30);
        chk("glitch_busy",   busy_n[1], 0);
        chk("glitch_pulses", pe_n[1] + fe_n[1] + ov_n[1], 0);
        chk("glitch_count",  occ(1), 0);
        send(1, 7, 'h55, 2, 0, 2, 0, 0, -1);
        idle(4);
        chk("o72_byte",   head(1), 'h55);
        chk("o72_count",  occ(1), 1);
        chk("o72_errors", pe_n[1] + fe_n[1], 0);

        // reset mid-frame
        base = pe_n[0] + fe_n[0] + ov_n[0];
        send(0, 8, 'hF0, 1, 0, 1, 0, 0, 3);
        chk("midrst_busy",  int'(busy[0]), 0);
        chk("midrst_dv",    int'(dv0), 0);
        chk("midrst_count", occ(0), 0);
        chk("midrst_byte",  head(0), 0);
        chk("midrst_other_count", occ(1), 0);
        idle(200);
        chk("midrst_no_pulse", pe_n[0] + fe_n[0] + ov_n[0] - base, 0);
        send(0, 8, 'hF7, 1, 0, 1, 0, 0, -1);
        idle(4);
        chk("post_rst_byte",  head(0), 'hF7);
        chk("post_rst_count", occ(0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
